// File: rtl/ip_ycbcr_pkg.sv
// Shared constants and types for the 4:4:4 -> 4:2:2 chroma subsampler.
// Rounding constants are selected by the FIR_RND parameter of the top.
package ip_ycbcr_pkg;

    localparam int   LAT422   = 3;
    localparam logic C_SEL_CB = 1'b0;
    localparam logic C_SEL_CR = 1'b1;
    localparam int   RND_2TAP = 1;
    localparam int   RND_3TAP = 2;

    typedef struct packed {
        logic vld;
        logic hstr;
        logic hend;
        logic ph;
    } sync_t;

    function automatic int rnd_const(input int fir_rnd, input int taps_rnd);
        return (fir_rnd != 0) ? taps_rnd : 0;
    endfunction

endpackage

// File: rtl/ip_chroma_tap.sv
// Per-channel chroma window with edge replication and pair filter.
// Macro YCBCR422_FIR_EN selects the 3-tap [1 2 1]/4 filter instead of the 2-tap average.
module ip_chroma_tap
    import ip_ycbcr_pkg::*;
#(
    parameter int DCW     = 13,
    parameter int FIR_RND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [DCW-1:0] c_i,
    input  logic                  ld_i,
    input  logic                  first_i,
    input  logic                  part_i,
    output logic signed [DCW-1:0] f_o
);

    logic signed [DCW-1:0] c1_q;
    logic signed [DCW-1:0] f_q;
    logic signed [DCW-1:0] f_d;
    logic signed [DCW-1:0] pair_s;

`ifdef YCBCR422_FIR_EN
    localparam int RND = rnd_const(FIR_RND, RND_3TAP);
    logic signed [DCW-1:0] c2_q;
    logic signed [DCW-1:0] left_s;
    logic signed [DCW+1:0] sum_s;
    logic                  unused_s;
    assign unused_s = ^sum_s[1:0];
`else
    localparam int RND = rnd_const(FIR_RND, RND_2TAP);
    logic signed [DCW:0]   sum_s;
    logic                  unused_s;
    assign unused_s = first_i ^ sum_s[0];
`endif

    // Filter the pair whose first pixel sits in c1_q; missing neighbours replicate c1_q.
    always_comb begin
        pair_s = part_i ? c_i : c1_q;
`ifdef YCBCR422_FIR_EN
        left_s = first_i ? c1_q : c2_q;
        sum_s  = (DCW+2)'(left_s) + ((DCW+2)'(c1_q) <<< 1) + (DCW+2)'(pair_s) + (DCW+2)'(RND);
        f_d    = ld_i ? sum_s[DCW+1:2] : f_q;
`else
        sum_s  = (DCW+1)'(c1_q) + (DCW+1)'(pair_s) + (DCW+1)'(RND);
        f_d    = ld_i ? sum_s[DCW:1] : f_q;
`endif
    end

    // Sample window and filtered-value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_q <= {DCW{1'b0}};
            f_q  <= {DCW{1'b0}};
`ifdef YCBCR422_FIR_EN
            c2_q <= {DCW{1'b0}};
`endif
        end else begin
            c1_q <= c_i;
            f_q  <= f_d;
`ifdef YCBCR422_FIR_EN
            c2_q <= c1_q;
`endif
        end
    end

    assign f_o = f_q;

endmodule

// File: rtl/ip_ycbcr444to422.sv
// 4:4:4 -> 4:2:2 chroma subsampler, fixed 3-cycle latency on data and framing.
// Optional macro YCBCR422_FIR_EN enables the 3-tap chroma filter in ip_chroma_tap.
module ip_ycbcr444to422
    import ip_ycbcr_pkg::*;
#(
    parameter int DYW     = 12,
    parameter int DCW     = 13,
    parameter int FIR_RND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DYW-1:0]        i_data_y,
    input  logic signed [DCW-1:0] i_data_cb,
    input  logic signed [DCW-1:0] i_data_cr,
    input  logic                  i_hstr,
    input  logic                  i_href,
    input  logic                  i_hend,
    output logic [DYW-1:0]        o_data_y,
    output logic signed [DCW-1:0] o_data_c,
    output logic                  o_c_sel,
    output logic                  o_hstr,
    output logic                  o_href,
    output logic                  o_hend
);

    logic                  ph_q, ph_d, act_q, act_d;
    sync_t                 s0_s, s1_q, s2_q;
    logic [DYW-1:0]        y1_q, y2_q, oy_q;
    logic signed [DCW-1:0] oc_q, oc_d, cb_f_s, cr_f_s;
    logic                  osel_q, osel_d, ohs_q, ohr_q, ohe_q;
    logic                  v0_s, ph0_s, part_s, ld_s;

    // Line tracking, phase, partner/load decisions and output mux.
    always_comb begin
        // Pixels are accepted only inside a line opened by hstr (also after a reset).
        v0_s   = i_href & (i_hstr | act_q);
        ph0_s  = i_hstr ? C_SEL_CB : ph_q;
        s0_s   = {v0_s, v0_s & i_hstr, v0_s & i_hend, ph0_s};
        ph_d   = v0_s ? ~ph0_s : ph_q;
        part_s = v0_s & ~i_hstr & ~s1_q.hend;
        ld_s   = s1_q.vld & (s1_q.ph == C_SEL_CB);
        if (v0_s & i_hstr) begin
            act_d = ~i_hend;
        end else if (v0_s & i_hend) begin
            act_d = 1'b0;
        end else begin
            act_d = act_q;
        end
        if (s2_q.vld) begin
            osel_d = s2_q.ph;
            oc_d   = (s2_q.ph == C_SEL_CR) ? cr_f_s : cb_f_s;
        end else begin
            osel_d = C_SEL_CB;
            oc_d   = {DCW{1'b0}};
        end
    end

    // Phase/line state, sync and Y delay line, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= 1'b0;
            act_q  <= 1'b0;
            s1_q   <= '{vld: 1'b0, hstr: 1'b0, hend: 1'b0, ph: 1'b0};
            s2_q   <= '{vld: 1'b0, hstr: 1'b0, hend: 1'b0, ph: 1'b0};
            y1_q   <= {DYW{1'b0}};
            y2_q   <= {DYW{1'b0}};
            oy_q   <= {DYW{1'b0}};
            oc_q   <= {DCW{1'b0}};
            osel_q <= 1'b0;
            ohs_q  <= 1'b0;
            ohr_q  <= 1'b0;
            ohe_q  <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            act_q  <= act_d;
            s1_q   <= s0_s;
            s2_q   <= s1_q;
            y1_q   <= i_data_y;
            y2_q   <= y1_q;
            oy_q   <= y2_q;
            oc_q   <= oc_d;
            osel_q <= osel_d;
            ohs_q  <= s2_q.hstr;
            ohr_q  <= s2_q.vld;
            ohe_q  <= s2_q.hend;
        end
    end

    ip_chroma_tap #(.DCW(DCW), .FIR_RND(FIR_RND)) u_tap_cb (
        .clk     (clk),
        .rst_n   (rst_n),
        .c_i     (i_data_cb),
        .ld_i    (ld_s),
        .first_i (s1_q.hstr),
        .part_i  (part_s),
        .f_o     (cb_f_s)
    );

    ip_chroma_tap #(.DCW(DCW), .FIR_RND(FIR_RND)) u_tap_cr (
        .clk     (clk),
        .rst_n   (rst_n),
        .c_i     (i_data_cr),
        .ld_i    (ld_s),
        .first_i (s1_q.hstr),
        .part_i  (part_s),
        .f_o     (cr_f_s)
    );

    assign o_data_y = oy_q;
    assign o_data_c = oc_q;
    assign o_c_sel  = osel_q;
    assign o_hstr   = ohs_q;
    assign o_href   = ohr_q;
    assign o_hend   = ohe_q;

endmodule

// File: tb/tb_ip_ycbcr444to422.sv
// Scoreboard bench for ip_ycbcr444to422 in the default 2-tap build with FIR_RND=1.
module tb_ip_ycbcr444to422;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [11:0]        i_data_y;
    logic signed [12:0] i_data_cb, i_data_cr;
    logic               i_hstr, i_href, i_hend;
    logic [11:0]        o_data_y;
    logic signed [12:0] o_data_c;
    logic               o_c_sel, o_hstr, o_href, o_hend;

    typedef struct {
        logic [11:0]        y;
        logic signed [12:0] c;
        logic               sel;
        logic               hs;
        logic               he;
        int                 t;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   ly[0:15], lcb[0:15], lcr[0:15];

    ip_ycbcr444to422 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_data_y  (i_data_y),
        .i_data_cb (i_data_cb),
        .i_data_cr (i_data_cr),
        .i_hstr    (i_hstr),
        .i_href    (i_href),
        .i_hend    (i_hend),
        .o_data_y  (o_data_y),
        .o_data_c  (o_data_c),
        .o_c_sel   (o_c_sel),
        .o_hstr    (o_hstr),
        .o_href    (o_href),
        .o_hend    (o_hend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h t=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: reset values, idle values, scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check_val("rst_outs", {o_href, o_hstr, o_hend, o_c_sel, o_data_c, o_data_y}, 32'd0);
        end else if (o_href) begin
            if (q.size() == 0) begin
                check_val("spurious_href", 32'(o_href), 32'd0);
            end else begin
                e = q.pop_front();
                check_val("y",    32'(o_data_y), 32'(e.y));
                check_val("c",    32'(o_data_c), 32'(e.c));
                check_val("csel", 32'(o_c_sel),  32'(e.sel));
                check_val("hstr", 32'(o_hstr),   32'(e.hs));
                check_val("hend", 32'(o_hend),   32'(e.he));
                check_val("lat",  32'(cyc),      32'(e.t));
            end
        end else begin
            check_val("idle_outs", {o_c_sel, o_data_c, o_hstr, o_hend}, 32'd0);
        end
    end

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            i_href    = 1'b0;
            i_hstr    = 1'b0;
            i_hend    = 1'b0;
            i_data_y  = 12'($urandom);
            i_data_cb = 13'($urandom);
            i_data_cr = 13'($urandom);
        end
    endtask

    task automatic drive_line(input int n, input bit hs, input bit he, input bit push);
        exp_t e;
        int   pj, cv;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            i_href    = 1'b1;
            i_hstr    = hs && (j == 0);
            i_hend    = he && (j == n - 1);
            i_data_y  = 12'(ly[j]);
            i_data_cb = 13'(lcb[j]);
            i_data_cr = 13'(lcr[j]);
            if (push) begin
                if (j % 2 == 0) begin
                    pj    = (j + 1 < n) ? j + 1 : j;
                    cv    = (lcb[j] + lcb[pj] + 1) >>> 1;
                    e.sel = 1'b0;
                end else begin
                    cv    = (lcr[j - 1] + lcr[j] + 1) >>> 1;
                    e.sel = 1'b1;
                end
                e.y  = 12'(ly[j]);
                e.c  = 13'(cv);
                e.hs = hs && (j == 0);
                e.he = he && (j == n - 1);
                e.t  = cyc + 3;
                q.push_back(e);
            end
        end
    endtask

    task automatic rand_line(input int n);
        for (int j = 0; j < n; j++) begin
            ly[j]  = int'($urandom_range(0, 4095));
            lcb[j] = int'($urandom_range(0, 8191)) - 4096;
            lcr[j] = int'($urandom_range(0, 8191)) - 4096;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        check_val("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            i_href    = 1'($urandom);
            i_hstr    = 1'($urandom);
            i_hend    = 1'($urandom);
            i_data_y  = 12'($urandom);
            i_data_cb = 13'($urandom);
            i_data_cr = 13'($urandom);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        // href without hstr after reset must stay silent
        rand_line(4);
        drive_line(4, 1'b0, 1'b0, 1'b0);
        idle(4);

        // flat line
        for (int j = 0; j < 8; j++) begin
            ly[j] = 'h800; lcb[j] = 'h40; lcr[j] = -'h40;
        end
        drive_line(8, 1'b1, 1'b1, 1'b1);
        idle(3);

        // ramp
        for (int j = 0; j < 4; j++) begin
            ly[j] = j * 100; lcb[j] = 16 * j; lcr[j] = -16 * (j + 1);
        end
        drive_line(4, 1'b1, 1'b1, 1'b1);
        idle(2);

        // odd line, replicated last pixel
        for (int j = 0; j < 5; j++) begin
            ly[j] = j + 1; lcb[j] = (j == 4) ? 160 : 0; lcr[j] = 7 * j;
        end
        drive_line(5, 1'b1, 1'b1, 1'b1);
        idle(2);

        // single-pixel line, then back-to-back lines with no gap
        rand_line(1);
        drive_line(1, 1'b1, 1'b1, 1'b1);
        rand_line(6);
        drive_line(6, 1'b1, 1'b1, 1'b1);
        rand_line(3);
        drive_line(3, 1'b1, 1'b1, 1'b1);
        idle(2);

        // hstr mid-line: truncated odd line then new line immediately
        rand_line(5);
        drive_line(5, 1'b1, 1'b0, 1'b1);
        rand_line(4);
        drive_line(4, 1'b1, 1'b1, 1'b1);
        idle(2);
        drain();

        // reset mid-line
        rand_line(3);
        drive_line(3, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_line(4);
        drive_line(4, 1'b0, 1'b1, 1'b0);
        idle(3);
        rand_line(6);
        drive_line(6, 1'b1, 1'b1, 1'b1);
        idle(3);

        // random lines with random gaps
        for (int l = 0; l < 12; l++) begin
            int n;
            n = int'($urandom_range(1, 12));
            rand_line(n);
            drive_line(n, 1'b1, 1'b1, 1'b1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(2);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
